base_gvnr_arb: RTL and testbench
================================

Name: base_gvnr_arb

Overview:
- Round-robin arbiter that shares one valid/ready output channel among `ways` requesters.
- Enforces a runtime-programmable minimum spacing of `cfg_gap` cycles between accepted transactions.
- Sits in front of a rate-limited shared resource (bus port, table write port).
- Replaces a fixed-n governor plus a separate arbiter: sequences grant, hold and cooldown in one block.

Parameters:
- ways, 4, number of requesters; legal range 2..16.
- gw, 4, width of `cfg_gap`; maximum gap is 2^gw-1 cycles.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- i_v  input  ways  per-requester valid.
- i_r  output  ways  per-requester ready; at most one bit set.
- o_v  output  1  valid to the shared resource.
- o_r  input  1  ready from the shared resource.
- o_sel  output  $clog2(ways)  index of the requester currently presented on o_v.
- cfg_gap  input  gw  minimum cycles from one accept to the next; quasi-static.

Behaviour:
- Transfer: a transfer occurs in a cycle where o_v & o_r = 1. The granted requester sees i_r=1 in that same cycle.
- Latency: request to o_v is combinational (zero cycles) in OPEN state.
- Protocol: requesters must hold i_v until i_r. Dropping i_v while in HOLD is a protocol violation and is covered by an assertion.

States:
- OPEN: grant = first requester with i_v set, searching from index ptr upward with wrap.
  - o_v = |i_v; o_sel = grant index; i_r[grant] = o_r.
  - o_v & ~o_r -> HOLD, latching the grant index.
  - Transfer with eff_gap>1 -> COOL with cnt = eff_gap-1.
  - Transfer with eff_gap<=1 -> stay in OPEN (back-to-back allowed).
- HOLD: grant frozen to the latched index; new higher-priority i_v is ignored.
  - o_v = 1; i_r[latched] = o_r.
  - On transfer: -> COOL or OPEN, using the same eff_gap rule as OPEN.
- COOL: o_v = 0, i_r = 0, cnt decrements by 1 per cycle.
  - When cnt reaches 1 -> OPEN. COOL therefore lasts exactly eff_gap-1 cycles.
- eff_gap: cfg_gap sampled in the transfer cycle. Values 0 and 1 both mean "no spacing". Changing cfg_gap during COOL does not alter the running count.

Pointer:
- ptr updates only on a transfer, to (granted index + 1) mod ways.
- Wrap from ways-1 to 0.

Reset:
- state = OPEN, ptr = 0, cnt = 0, latched grant = 0.
- While reset is high: o_v = 0, i_r = 0, o_sel = 0.
- Reset during HOLD or COOL aborts immediately. No transfer is reported in the reset cycle.

Simultaneous events:
- A transfer in the same cycle as a cfg_gap change uses the new value.
- All requesters valid at once are served strictly in rotation.

Optional Feature:
- Macro: BASE_GVNR_ARB_STALL_CNT_EN
- Defined:
  - Adds output `stall_cnt` (16 bits, saturating).
  - Increments once per cycle in which |i_v is set and no transfer occurs (HOLD, COOL, or OPEN with o_r=0).
  - Cleared by reset.
- Undefined: port and counter are absent. All other behaviour is identical.

Decomposition:
- Package base_gvnr_arb_pkg:
  - State enum {OPEN, HOLD, COOL}, 2 bits.
  - Localparam function for the `o_sel` width.
- Sub-module base_gvnr_rr_pick: purely combinational rotating-priority picker.
  - Inputs: req[ways], ptr.
  - Outputs: any, one-hot grant, encoded index.
  - Instantiated once.
- Top level holds the state register, cnt, ptr, the hold latch and the optional stall counter.

Test Plan:
- ways=4, cfg_gap=0, i_v=4'b1111, o_r=1 constant: transfers every cycle; o_sel sequence 0,1,2,3,0.
- cfg_gap=3, i_v[2]=1 only, o_r=1: transfers at cycles t, t+3, t+6; o_v=0 in the two cycles between transfers.
- i_v[1]=1, o_r=0 for 4 cycles, i_v[0] raised on cycle 2 (ptr=0): o_sel stays 1 through HOLD; i_r[1] pulses when o_r rises; next grant is 0 only after the pointer wraps.
- cfg_gap changes 5->2 during COOL after a transfer with gap 5: COOL still lasts 4 cycles; the next spacing is 2.
- Reset asserted mid-COOL and mid-HOLD: next cycle o_v=0, i_r=0; after release, i_v=4'b1000 is granted with o_sel=3 immediately and ptr becomes 0.
- With BASE_GVNR_ARB_STALL_CNT_EN, cfg_gap=4 and a continuous request on one requester: stall_cnt increases by 3 per transfer.

Source files
------------

// File: rtl/base_gvnr_arb_pkg.sv
// ============================================================================
//  base_gvnr_arb_pkg : shared types and helpers for the governed RR arbiter
//  Rev 1.0
// ============================================================================
`default_nettype none

package base_gvnr_arb_pkg;

  typedef enum logic [1:0] {
    ST_OPEN = 2'd0,
    ST_HOLD = 2'd1,
    ST_COOL = 2'd2
  } state_t;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/base_gvnr_rr_pick.sv
// ============================================================================
//  base_gvnr_rr_pick : combinational rotating-priority picker (search from ptr)
//  Rev 1.0
// ============================================================================
`default_nettype none

module base_gvnr_rr_pick
  import base_gvnr_arb_pkg::*;
#(
  parameter int ways = 4,
  parameter int sw   = sel_width(ways)
) (
  input  logic [ways-1:0] req,
  input  logic [sw-1:0]   ptr,
  output logic            any,
  output logic [ways-1:0] grant,
  output logic [sw-1:0]   idx
);

  always_comb begin : p_pick
    int j;
    any   = 1'b0;
    grant = '0;
    idx   = '0;
    j     = 0;
    for (int i = 0; i < ways; i++) begin
      // ptr is always < ways, so one subtraction folds the wrap
      j = int'(ptr) + i;
      if (j >= ways) j = j - ways;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = sw'(j);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/base_gvnr_arb.sv
// ============================================================================
//  base_gvnr_arb : round-robin arbiter with programmable inter-accept cooldown
//  Optional stall counter output enabled by BASE_GVNR_ARB_STALL_CNT_EN.
//  Rev 1.0
// ============================================================================
`default_nettype none

module base_gvnr_arb
  import base_gvnr_arb_pkg::*;
#(
  parameter int ways = 4,
  parameter int gw   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ways-1:0]            i_v,
  output logic [ways-1:0]            i_r,
  output logic                       o_v,
  input  logic                       o_r,
  output logic [sel_width(ways)-1:0] o_sel,
  input  logic [gw-1:0]              cfg_gap
`ifdef BASE_GVNR_ARB_STALL_CNT_EN
  ,
  output logic [15:0]                stall_cnt
`endif
);

  localparam int             sw       = sel_width(ways);
  localparam logic [sw-1:0]  last_idx = sw'(ways - 1);
  localparam logic [sw-1:0]  one_idx  = sw'(1);
  localparam logic [gw-1:0]  gap_one  = gw'(1);

  state_t          state, state_nx;
  logic [sw-1:0]   ptr, ptr_nx;
  logic [sw-1:0]   hold_idx, hold_nx;
  logic [gw-1:0]   cnt, cnt_nx;

  logic            pick_any;
  logic [ways-1:0] pick_oh;
  logic [sw-1:0]   pick_idx;
  logic [sw-1:0]   gnt_idx;
  logic            xfer;
  logic            long_gap;

  base_gvnr_rr_pick #(
    .ways (ways),
    .sw   (sw)
  ) u_pick (
    .req   (i_v),
    .ptr   (ptr),
    .any   (pick_any),
    .grant (pick_oh),
    .idx   (pick_idx)
  );

  assign gnt_idx  = (state == ST_HOLD) ? hold_idx : pick_idx;
  assign xfer     = o_v & o_r;
  assign long_gap = (cfg_gap > gap_one);

  always_comb begin
    o_v   = 1'b0;
    i_r   = '0;
    o_sel = '0;
    if (!reset) begin
      unique case (state)
        ST_OPEN: begin
          o_v   = pick_any;
          i_r   = pick_oh & {ways{o_r}};
          o_sel = pick_idx;
        end
        ST_HOLD: begin
          o_v   = 1'b1;
          i_r   = (ways'(1) << hold_idx) & {ways{o_r}};
          o_sel = hold_idx;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ptr_nx   = ptr;
    hold_nx  = hold_idx;
    if (xfer) begin
      ptr_nx = (gnt_idx == last_idx) ? '0 : gnt_idx + one_idx;
      if (long_gap) begin
        state_nx = ST_COOL;
        cnt_nx   = cfg_gap - gap_one;
      end else begin
        state_nx = ST_OPEN;
      end
    end else begin
      unique case (state)
        ST_OPEN: begin
          // offered but not taken: freeze this grant until it completes
          if (pick_any) begin
            state_nx = ST_HOLD;
            hold_nx  = pick_idx;
          end
        end
        ST_COOL: begin
          if (cnt <= gap_one) begin
            state_nx = ST_OPEN;
            cnt_nx   = '0;
          end else begin
            cnt_nx   = cnt - gap_one;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_OPEN;
      ptr      <= '0;
      cnt      <= '0;
      hold_idx <= '0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      cnt      <= cnt_nx;
      hold_idx <= hold_nx;
    end
  end

`ifdef BASE_GVNR_ARB_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if ((|i_v) && !xfer && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

  // a held requester must keep its request up until it is accepted
  hold_keeps_valid: assert property (
    @(posedge clk) disable iff (reset) (state == ST_HOLD) |-> i_v[hold_idx]
  );

endmodule

`default_nettype wire

// File: tb/tb_base_gvnr_arb.sv
// ============================================================================
//  tb_base_gvnr_arb : vector table + scoreboard bench for base_gvnr_arb
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_base_gvnr_arb;

  logic       clk;
  logic       reset;
  logic [3:0] i_v;
  logic [3:0] i_r;
  logic       o_v;
  logic       o_r;
  logic [1:0] o_sel;
  logic [3:0] cfg_gap;
`ifdef BASE_GVNR_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  base_gvnr_arb #(
    .ways (4),
    .gw   (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .i_v     (i_v),
    .i_r     (i_r),
    .o_v     (o_v),
    .o_r     (o_r),
    .o_sel   (o_sel),
    .cfg_gap (cfg_gap)
`ifdef BASE_GVNR_ARB_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] iv;
    logic       orr;
    logic [3:0] gap;
    logic       ev;
    logic [3:0] eir;
    logic [1:0] esel;
  } vec_t;

  localparam int NV = 38;
  vec_t tbl [NV];
  vec_t sb_q [$];

  function automatic vec_t mk(input logic rst, input logic [3:0] iv, input logic orr,
                              input logic [3:0] gap, input logic ev, input logic [3:0] eir,
                              input logic [1:0] esel);
    vec_t v;
    v.rst = rst; v.iv = iv; v.orr = orr; v.gap = gap;
    v.ev = ev; v.eir = eir; v.esel = esel;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step=%0d actual=%0h required=%0h", name, idx, act, exp);
    end
  endtask

  initial begin
    vec_t e;
    int   tx [$];
    int   k;

    // rst, i_v, o_r, gap | o_v, i_r, o_sel
    tbl[0]  = mk(1, 4'hF, 1, 0, 0, 4'h0, 0);
    tbl[1]  = mk(0, 4'hF, 1, 0, 1, 4'h1, 0);
    tbl[2]  = mk(0, 4'hF, 1, 0, 1, 4'h2, 1);
    tbl[3]  = mk(0, 4'hF, 1, 0, 1, 4'h4, 2);
    tbl[4]  = mk(0, 4'hF, 1, 0, 1, 4'h8, 3);
    tbl[5]  = mk(0, 4'hF, 1, 0, 1, 4'h1, 0);
    tbl[6]  = mk(0, 4'h4, 1, 3, 1, 4'h4, 2);
    tbl[7]  = mk(0, 4'h4, 1, 3, 0, 4'h0, 0);
    tbl[8]  = mk(0, 4'h4, 1, 3, 0, 4'h0, 0);
    tbl[9]  = mk(0, 4'h4, 1, 3, 1, 4'h4, 2);
    tbl[10] = mk(0, 4'h4, 1, 3, 0, 4'h0, 0);
    tbl[11] = mk(0, 4'h4, 1, 3, 0, 4'h0, 0);
    tbl[12] = mk(0, 4'h4, 1, 3, 1, 4'h4, 2);
    tbl[13] = mk(0, 4'h0, 1, 0, 0, 4'h0, 0);
    tbl[14] = mk(0, 4'h0, 1, 0, 0, 4'h0, 0);
    tbl[15] = mk(0, 4'h8, 1, 0, 1, 4'h8, 3);
    tbl[16] = mk(0, 4'h2, 0, 0, 1, 4'h0, 1);
    tbl[17] = mk(0, 4'h3, 0, 0, 1, 4'h0, 1);
    tbl[18] = mk(0, 4'h3, 0, 0, 1, 4'h0, 1);
    tbl[19] = mk(0, 4'h3, 0, 0, 1, 4'h0, 1);
    tbl[20] = mk(0, 4'h3, 1, 0, 1, 4'h2, 1);
    tbl[21] = mk(0, 4'h1, 1, 0, 1, 4'h1, 0);
    tbl[22] = mk(0, 4'h1, 1, 5, 1, 4'h1, 0);
    tbl[23] = mk(0, 4'h1, 1, 2, 0, 4'h0, 0);
    tbl[24] = mk(0, 4'h1, 1, 2, 0, 4'h0, 0);
    tbl[25] = mk(0, 4'h1, 1, 2, 0, 4'h0, 0);
    tbl[26] = mk(0, 4'h1, 1, 2, 0, 4'h0, 0);
    tbl[27] = mk(0, 4'h1, 1, 2, 1, 4'h1, 0);
    tbl[28] = mk(0, 4'h1, 1, 2, 0, 4'h0, 0);
    tbl[29] = mk(0, 4'h1, 1, 2, 1, 4'h1, 0);
    tbl[30] = mk(1, 4'h1, 1, 2, 0, 4'h0, 0);
    tbl[31] = mk(0, 4'h8, 1, 0, 1, 4'h8, 3);
    tbl[32] = mk(0, 4'h4, 0, 0, 1, 4'h0, 2);
    tbl[33] = mk(0, 4'h4, 0, 0, 1, 4'h0, 2);
    tbl[34] = mk(1, 4'h4, 1, 0, 0, 4'h0, 0);
    tbl[35] = mk(0, 4'h8, 1, 0, 1, 4'h8, 3);
    tbl[36] = mk(0, 4'h9, 1, 0, 1, 4'h1, 0);
    tbl[37] = mk(0, 4'h0, 1, 0, 0, 4'h0, 0);

    reset   = 1'b1;
    i_v     = '0;
    o_r     = 1'b0;
    cfg_gap = '0;

    for (int n = 0; n < NV; n++) begin
      @(posedge clk);
      #1;
      reset   = tbl[n].rst;
      i_v     = tbl[n].iv;
      o_r     = tbl[n].orr;
      cfg_gap = tbl[n].gap;
      sb_q.push_back(tbl[n]);
      @(negedge clk);
      e = sb_q.pop_front();
      chk("o_v", n, 32'(o_v), 32'(e.ev));
      chk("i_r", n, 32'(i_r), 32'(e.eir));
      if (e.ev || e.rst) chk("o_sel", n, 32'(o_sel), 32'(e.esel));
    end

    // steady single requester with gap 3: accepts exactly three cycles apart
    @(posedge clk);
    #1;
    reset   = 1'b0;
    i_v     = 4'b0100;
    o_r     = 1'b1;
    cfg_gap = 4'd3;
    for (int c = 0; c < 40 && tx.size() < 3; c++) begin
      @(negedge clk);
      if (o_v && o_r) begin
        tx.push_back(c);
        chk("gap_i_r", c, 32'(i_r), 32'h4);
      end
    end
    chk("gap_xfers", 0, 32'(tx.size()), 32'd3);
    if (tx.size() == 3) begin
      chk("gap_space0", 0, 32'(tx[1] - tx[0]), 32'd3);
      chk("gap_space1", 1, 32'(tx[2] - tx[1]), 32'd3);
    end

`ifdef BASE_GVNR_ARB_STALL_CNT_EN
    // each gap-4 cooldown adds three stalled cycles
    @(posedge clk);
    #1;
    reset   = 1'b1;
    i_v     = 4'b0001;
    cfg_gap = 4'd4;
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    k = 0;
    for (int c = 0; c < 40 && k < 3; c++) begin
      @(negedge clk);
      if (o_v && o_r) begin
        chk("stall_cnt", k, 32'(stall_cnt), 32'(3 * k));
        k++;
      end
    end
    chk("stall_xfers", 0, 32'(k), 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
